// File: rtl/serial_sub.sv
// Digit-serial subtractor: D = X - Y - BIN, DIGIT bits per clock with a registered borrow.
// start/busy/done handshake; result, borrow-out and signed overflow held until the next completion.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b,
    output logic             ov
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] rs;
    logic             br;
    logic             x_sign;
    logic             y_sign;
    logic [CW-1:0]    cnt;

    // Bit DIGIT of the widened difference is the borrow out of this digit.
    function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] a,
                                                 input logic [DIGIT-1:0] s,
                                                 input logic             c);
        return {1'b0, a} - {1'b0, s} - {{DIGIT{1'b0}}, c};
    endfunction

    function automatic logic signed_ov(input logic sx, input logic sy, input logic sd);
        return (sx != sy) && (sd != sx);
    endfunction

    logic [DIGIT:0]         diff;
    logic [WIDTH+DIGIT-1:0] rs_ext;
    logic [WIDTH-1:0]       rs_next;

    always_comb begin
        diff    = sub_digit(xs[DIGIT-1:0], ys[DIGIT-1:0], br);
        rs_ext  = {diff[DIGIT-1:0], rs};
        rs_next = rs_ext[WIDTH+DIGIT-1:DIGIT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            b      <= 1'b0;
            ov     <= 1'b0;
            xs     <= '0;
            ys     <= '0;
            rs     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            x_sign <= 1'b0;
            y_sign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs     <= x;
                        ys     <= y;
                        br     <= bin;
                        x_sign <= x[WIDTH-1];
                        y_sign <= y[WIDTH-1];
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    xs  <= xs >> DIGIT;
                    ys  <= ys >> DIGIT;
                    rs  <= rs_next;
                    br  <= diff[DIGIT];
                    cnt <= cnt + 1'b1;
                    // Last digit: publish result; intermediate digits never reach d.
                    if (cnt == LAST) begin
                        d     <= rs_next;
                        b     <= diff[DIGIT];
                        ov    <= signed_ov(x_sign, y_sign, rs_next[WIDTH-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: four configurations (8/1, 8/4, 4/1, 4/2) driven from one directed sequence,
// expected results queued at start and compared when each instance pulses done.
module tb_serial_sub;

    typedef struct packed {
        logic [7:0]  d;
        logic        b;
        logic        ov;
        logic [31:0] due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start = 4'b0;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;
    logic       bin = 1'b0;

    logic       busy0, done0, b0, ov0;
    logic [7:0] d0;
    logic       busy1, done1, b1, ov1;
    logic [7:0] d1;
    logic       busy2, done2, b2, ov2;
    logic [3:0] d2;
    logic       busy3, done3, b3, ov3;
    logic [3:0] d3;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(start[0]), .x(x), .y(y), .bin(bin),
        .busy(busy0), .done(done0), .d(d0), .b(b0), .ov(ov0));
    serial_sub #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .start(start[1]), .x(x), .y(y), .bin(bin),
        .busy(busy1), .done(done1), .d(d1), .b(b1), .ov(ov1));
    serial_sub #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst(rst), .start(start[2]), .x(x[3:0]), .y(y[3:0]), .bin(bin),
        .busy(busy2), .done(done2), .d(d2), .b(b2), .ov(ov2));
    serial_sub #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst(rst), .start(start[3]), .x(x[3:0]), .y(y[3:0]), .bin(bin),
        .busy(busy3), .done(done3), .d(d3), .b(b3), .ov(ov3));

    function automatic int width_of(int sel);
        return (sel < 2) ? 8 : 4;
    endfunction

    function automatic int ncyc_of(int sel);
        case (sel)
            0:       return 8;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic exp_t model(int w, logic [7:0] xv, logic [7:0] yv, logic bv, int due);
        exp_t       e;
        int         diff;
        logic [7:0] dv;
        diff = int'(xv) - int'(yv) - int'(bv);
        dv   = 8'(diff & ((1 << w) - 1));
        e.d   = dv;
        e.b   = (diff < 0);
        e.ov  = (xv[w-1] != yv[w-1]) && (dv[w-1] != xv[w-1]);
        e.due = 32'(due);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input exp_t e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int qsize(int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop(input int sel, output exp_t e);
        case (sel)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            2:       e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    // Called on every observed done pulse.
    task automatic mon(input int sel, input logic [7:0] dv, input logic bv, input logic ovv);
        exp_t e;
        int   n;
        n = qsize(sel);
        chk($sformatf("u%0d_done_expected", sel), 32'(n > 0), 32'd1);
        if (n > 0) begin
            pop(sel, e);
            chk($sformatf("u%0d_d", sel), 32'(dv), 32'(e.d));
            chk($sformatf("u%0d_b", sel), 32'(bv), 32'(e.b));
            chk($sformatf("u%0d_ov", sel), 32'(ovv), 32'(e.ov));
            chk($sformatf("u%0d_latency", sel), 32'(cyc), e.due);
        end
    endtask

    always @(negedge clk) if (done0) mon(0, d0, b0, ov0);
    always @(negedge clk) if (done1) mon(1, d1, b1, ov1);
    always @(negedge clk) if (done2) mon(2, {4'h0, d2}, b2, ov2);
    always @(negedge clk) if (done3) mon(3, {4'h0, d3}, b3, ov3);

    // Drive at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int sel, input logic [7:0] xv, input logic [7:0] yv, input logic bv);
        x   = xv;
        y   = yv;
        bin = bv;
        start[sel] = 1'b1;
        push(sel, model(width_of(sel), xv, yv, bv, cyc + 1 + ncyc_of(sel)));
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_d"}, 32'(d0), 32'd0);
        chk({tag, "_b"}, 32'(b0), 32'd0);
        chk({tag, "_ov"}, 32'(ov0), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero0("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic 8-bit serial op with busy tracking over all eight digit cycles
        issue(0, 8'h05, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("u0_busy_run", 32'(busy0), 32'd1);
            @(negedge clk);
        end
        chk("u0_busy_after", 32'(busy0), 32'd0);
        chk("u0_done_pulse", 32'(done0), 32'd1);
        @(negedge clk);
        chk("u0_done_drop", 32'(done0), 32'd0);

        issue(0, 8'h03, 8'h05, 1'b0);
        repeat (10) @(negedge clk);
        issue(0, 8'h80, 8'h01, 1'b0);
        repeat (10) @(negedge clk);
        issue(0, 8'h00, 8'h00, 1'b1);
        repeat (10) @(negedge clk);

        // DIGIT=4, with the second start landing in the DONE cycle
        issue(1, 8'hA7, 8'h3C, 1'b0);
        repeat (2) @(negedge clk);
        issue(1, 8'h12, 8'h34, 1'b1);
        repeat (2) @(negedge clk);
        issue(1, 8'h7F, 8'h80, 1'b0);
        repeat (5) @(negedge clk);

        // start during RUN is ignored; operand changes after acceptance do nothing
        issue(0, 8'h5A, 8'h21, 1'b0);
        repeat (2) @(negedge clk);
        x = 8'hFF;
        y = 8'h00;
        bin = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x   = 8'($urandom);
            y   = 8'($urandom);
            bin = ~bin;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("u0_idle_after_ignored", 32'(busy0), 32'd0);

        // Reset in RUN cycle 4 aborts with no done pulse
        issue(0, 8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk_zero0("midrst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(0, 8'hC8, 8'h64, 1'b1);
        repeat (10) @(negedge clk);

        // Exhaustive 4-bit sweeps, back-to-back
        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int bi = 0; bi < 2; bi++) begin
                    issue(2, 8'(xi), 8'(yi), 1'(bi));
                    repeat (4) @(negedge clk);
                end
        repeat (3) @(negedge clk);
        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int bi = 0; bi < 2; bi++) begin
                    issue(3, 8'(xi), 8'(yi), 1'(bi));
                    repeat (2) @(negedge clk);
                end
        repeat (6) @(negedge clk);

        for (int s = 0; s < 4; s++)
            chk($sformatf("u%0d_queue_drained", s), 32'(qsize(s)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Parametrised multi-cycle subtractor computing D = X - Y - BIN on WIDTH-bit operands. It processes DIGIT bits per clock and carries a registered borrow between digits. It is the sequential successor of the team's half/full-subtractor cells. It sits in datapaths where area matters more than latency, and uses a start/busy/done handshake toward the controlling FSM.

Parameters:
WIDTH  8  operand and result width in bits; must be >= 2
DIGIT  1  bits processed per clock; must divide WIDTH exactly; NCYC = WIDTH/DIGIT

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous active-high reset
start  input   1      request new operation; accepted only in IDLE or DONE
x      input   WIDTH  minuend, sampled on the accepting edge only
y      input   WIDTH  subtrahend, sampled on the accepting edge only
bin    input   1      borrow-in, sampled on the accepting edge only
busy   output  1      1 while state = RUN
done   output  1      one-cycle pulse; result valid
d      output  WIDTH  difference (x - y - bin) mod 2^WIDTH
b      output  1      final borrow-out; 1 iff x < y + bin (unsigned)
ov     output  1      signed overflow of x - y - bin (two's complement)

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock port is clk and the reset port is rst; this polarity and synchronicity are fixed.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, d=0, b=0, ov=0. Operand shift registers, borrow register and digit counter clear to 0. rst has priority over start.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 captures x, y and bin into internal registers, sets cnt=0 and moves to RUN.
  - RUN, each edge: take the low DIGIT bits xd and yd and compute xd - yd - br over DIGIT+1 bits. Store the low DIGIT bits into the result shift register at its MSB end (shift right by DIGIT). br <= the bit-DIGIT borrow. Shift the x and y registers right by DIGIT. cnt increments.
  - RUN, edge where cnt = NCYC-1: also load the d, b and ov output registers, set done=1 and move to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back), with done returning to 0. Otherwise go to IDLE.
- Latency: start accepted at edge k gives done=1 after edge k+NCYC. Back-to-back throughput is one result per NCYC+1 cycles.
- start while in RUN is ignored; no operand capture and no restart.
- x, y and bin may change freely after the accepting edge without affecting the result.
- d, b and ov change only on the completing edge (or reset). They hold the last result through IDLE and the next RUN; no intermediate digits are visible.
- ov = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]), using the captured x and y and the final d.
- b equals the borrow out of the most significant digit.
- rst asserted mid-RUN aborts the operation: no done pulse, outputs cleared to 0.
- cnt width is clog2(NCYC), minimum 1 bit. NCYC=1 (DIGIT=WIDTH) is legal: RUN lasts one edge, latency 1.

Test Plan:
- WIDTH=8, DIGIT=1: x=0x05, y=0x03, bin=0 -> busy for 8 cycles, then done pulse; d=0x02, b=0, ov=0.
- WIDTH=8, DIGIT=1: x=0x03, y=0x05 -> d=0xFE, b=1, ov=0. Then x=0x80, y=0x01 -> d=0x7F, b=0, ov=1. Then x=0x00, y=0x00, bin=1 -> d=0xFF, b=1, ov=0.
- WIDTH=8, DIGIT=4: x=0xA7, y=0x3C, bin=0 -> done 2 cycles after start, d=0x6B, b=0, ov=1 (-89 - 60 overflows). Issue start again in the DONE cycle -> accepted, no idle gap.
- start pulsed at RUN cycle 3 with different x, y -> ignored; the original result is delivered on schedule. Operand inputs toggled after acceptance -> no effect on the result.
- Assert rst at RUN cycle 4 of a WIDTH=8, DIGIT=1 operation -> next cycle busy=0, done=0, d=0, b=0, ov=0, and no done pulse follows. A new start then completes normally.
- WIDTH=4, DIGIT=1 and DIGIT=2: exhaustive sweep of all x, y and bin combinations (512 ops) checked against the golden (x - y - bin) mod 16, the borrow and the signed overflow, with done latency equal to NCYC on every op.
